fp_normalizer: RTL and testbench

- Back-end stage of the FP adder datapath. The front end orders operands by magnitude; this block sits at the other end and packs the raw sum back into a `float`.
- It accepts an unnormalized sum: sign, larger-operand biased exponent, and carry/hidden/fraction mantissa plus guard/round/sticky bits.
- It normalizes iteratively with one left shift per cycle, rounds, and emits a packed `float` over a valid/ready handshake.

---
 rtl/float_pkg.sv | 33 +++
 rtl/fp_round_unit.sv | 27 ++
 rtl/fp_normalizer.sv | 157 +++++++++++++++
 tb/tb_fp_normalizer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Single-precision float layout plus shared types for the FP adder back end.
// fp_normalizer's rounding mode is set by FP_NORM_ROUND_NEAREST_EN (see fp_round_unit).
package float_pkg;

  localparam int unsigned EXPONENT_BITS = 8;
  localparam int unsigned FRACTION_BITS = 23;

  typedef struct packed {
    logic                     sign;
    logic [EXPONENT_BITS-1:0] exponent;
    logic [FRACTION_BITS-1:0] fraction;
  } float;

  // Carry, hidden and fraction bits of an unnormalized sum.
  localparam int unsigned MANT_W = FRACTION_BITS + 2;

  localparam logic [EXPONENT_BITS-1:0] EXP_MAX = '1;

  typedef struct packed {
    logic guard;
    logic round;
    logic sticky;
  } grs_t;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StShift,
    StRound,
    StDone
  } norm_state_t;

endpackage

// File: rtl/fp_round_unit.sv
// Combinational rounding increment for the normalizer.
// FP_NORM_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise truncation.
module fp_round_unit
  import float_pkg::*;
#(
  parameter int unsigned MantW = MANT_W
) (
  input  logic [MantW-1:0] mant_i,
  input  grs_t             grs_i,
  output logic [MantW-1:0] mant_o,
  output logic             carry_o
);

`ifdef FP_NORM_ROUND_NEAREST_EN
  logic inc;
  assign inc    = grs_i.guard & (grs_i.round | grs_i.sticky | mant_i[0]);
  assign mant_o = mant_i + MantW'(inc);
`else
  logic unused_grs;
  assign unused_grs = ^grs_i;
  assign mant_o     = mant_i;
`endif

  // The carry bit is clear on entry, so a set top bit means the increment overflowed.
  assign carry_o = mant_o[MantW-1];

endmodule

// File: rtl/fp_normalizer.sv
// Back end of the FP adder: normalizes a raw sum one left shift per cycle, rounds, packs a float.
// Rounding mode selected by FP_NORM_ROUND_NEAREST_EN inside fp_round_unit.
module fp_normalizer
  import float_pkg::*;
#(
  parameter int unsigned EXP_W  = EXPONENT_BITS,
  parameter int unsigned FRAC_W = FRACTION_BITS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exponent,
  input  logic [FRAC_W+1:0] in_mant,
  input  logic [2:0]        in_grs,
  output logic              out_valid,
  input  logic              out_ready,
  output float              out_result,
  output logic              out_overflow,
  output logic              out_underflow
);

  localparam int unsigned MW = FRAC_W + 2;
  localparam logic [EXP_W:0] ExpAllOnes = {1'b0, EXP_MAX};
  localparam logic [EXP_W:0] ExpOne     = (EXP_W + 1)'(1);

  norm_state_t     state_q, state_d;
  logic            sign_q, sign_d;
  logic [EXP_W:0]  exp_q, exp_d;
  logic [MW-1:0]   mant_q, mant_d;
  grs_t            grs_q, grs_d;
  float            result_q, result_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic [MW-1:0]   rnd_mant;
  logic            rnd_carry;
  logic [MW-1:0]   mant_r;
  logic [EXP_W:0]  exp_r;

  fp_round_unit #(
    .MantW (MW)
  ) u_round (
    .mant_i  (mant_q),
    .grs_i   (grs_q),
    .mant_o  (rnd_mant),
    .carry_o (rnd_carry)
  );

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    grs_d    = grs_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    mant_r   = rnd_carry ? (rnd_mant >> 1) : rnd_mant;
    exp_r    = exp_q + {{EXP_W{1'b0}}, rnd_carry};

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = {1'b0, in_exponent};
          mant_d  = in_mant;
          grs_d   = in_grs;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (mant_q == '0 && grs_q == '0) begin
          result_d = '0;
          state_d  = StDone;
        end else if (mant_q[MW-1]) begin
          mant_d = mant_q >> 1;
          grs_d  = '{guard: mant_q[0], round: grs_q.guard, sticky: grs_q.round | grs_q.sticky};
          exp_d  = exp_q + 1'b1;
          if (exp_d >= ExpAllOnes) begin
            result_d = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
            ovf_d    = 1'b1;
            state_d  = StDone;
          end else begin
            state_d = StRound;
          end
        end else if (mant_q[FRAC_W]) begin
          state_d = StRound;
        end else begin
          state_d = StShift;
        end
      end
      StShift: begin
        // A shift that would leave the exponent at zero cannot yield a normal number.
        if (exp_q <= ExpOne) begin
          result_d = {sign_q, {(EXP_W + FRAC_W){1'b0}}};
          unf_d    = 1'b1;
          state_d  = StDone;
        end else begin
          mant_d = {mant_q[MW-2:0], grs_q.guard};
          grs_d  = '{guard: grs_q.round, round: grs_q.sticky, sticky: grs_q.sticky};
          exp_d  = exp_q - 1'b1;
          if (mant_q[FRAC_W-1]) begin
            state_d = StRound;
          end
        end
      end
      StRound: begin
        if (exp_r >= ExpAllOnes) begin
          result_d = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
          ovf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_r[EXP_W-1:0], mant_r[FRAC_W-1:0]};
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      grs_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      grs_q    <= grs_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign in_ready      = (state_q == StIdle) && !reset;
  assign out_valid     = (state_q == StDone);
  assign out_result    = result_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed, table-driven bench for fp_normalizer; expectations follow FP_NORM_ROUND_NEAREST_EN.
module tb_fp_normalizer;
  import float_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exponent;
  logic [24:0] in_mant;
  logic [2:0]  in_grs;
  logic        out_valid;
  logic        out_ready;
  float        out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic [31:0] res_bits;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mant;
    logic [2:0]  grs;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  fp_normalizer dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exponent   (in_exponent),
    .in_mant       (in_mant),
    .in_grs        (in_grs),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  assign res_bits = out_result;

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Issue one sum, measure latency from the accept edge (counted as 1), check the result.
  task automatic run_vec(input vec_t v, input bit release_out);
    int lat;
    bit got;
    @(negedge clock);
    check({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
    in_sign     = v.sign;
    in_exponent = v.exp;
    in_mant     = v.mant;
    in_grs      = v.grs;
    in_valid    = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clock);
      #1 lat++;
      if (out_valid) got = 1'b1;
    end
    if (!got) lat = -1;
    check({v.name, "_latency"}, 32'(lat), 32'(v.lat));
    check({v.name, "_result"}, res_bits, v.res);
    check({v.name, "_ovf"}, 32'(out_overflow), 32'(v.ovf));
    check({v.name, "_unf"}, 32'(out_underflow), 32'(v.unf));
    if (release_out) begin
      @(negedge clock);
      out_ready = 1'b1;
      @(posedge clock);
      #1 out_ready = 1'b0;
      check({v.name, "_released"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rnd_res, rnd_carry_res, rnd_ovf_res;
    logic        rnd_ovf_flag;
    logic [31:0] held;
    bit          seen;

`ifdef FP_NORM_ROUND_NEAREST_EN
    rnd_res       = 32'h40000000;
    rnd_carry_res = 32'h40400002;
    rnd_ovf_res   = 32'h7F800000;
    rnd_ovf_flag  = 1'b1;
`else
    rnd_res       = 32'h3FFFFFFF;
    rnd_carry_res = 32'h40400001;
    rnd_ovf_res   = 32'h7F7FFFFF;
    rnd_ovf_flag  = 1'b0;
`endif

    vecs.push_back('{1'b0, 8'd127, 25'h1800000, 3'b000, 32'h40400000, 1'b0, 1'b0, 3, "carry"});
    vecs.push_back('{1'b0, 8'd127, 25'h0200000, 3'b000, 32'h3E800000, 1'b0, 1'b0, 5, "cancel"});
    vecs.push_back('{1'b0, 8'd127, 25'h0000000, 3'b000, 32'h00000000, 1'b0, 1'b0, 2, "zero"});
    vecs.push_back('{1'b1, 8'd90,  25'h0000000, 3'b000, 32'h00000000, 1'b0, 1'b0, 2, "neg_zero"});
    vecs.push_back('{1'b0, 8'd1,   25'h0400000, 3'b000, 32'h00000000, 1'b0, 1'b1, 3, "underflow"});
    vecs.push_back('{1'b1, 8'd2,   25'h0100000, 3'b000, 32'h80000000, 1'b0, 1'b1, 4, "neg_underflow"});
    vecs.push_back('{1'b0, 8'd254, 25'h1800000, 3'b000, 32'h7F800000, 1'b1, 1'b0, 2, "overflow"});
    vecs.push_back('{1'b0, 8'd127, 25'h0FFFFFF, 3'b100, rnd_res, 1'b0, 1'b0, 3, "round"});
    vecs.push_back('{1'b0, 8'd127, 25'h1800001, 3'b000, 32'h40400000, 1'b0, 1'b0, 3, "tie_even"});
    vecs.push_back('{1'b0, 8'd127, 25'h1800003, 3'b000, rnd_carry_res, 1'b0, 1'b0, 3, "tie_odd"});
    vecs.push_back('{1'b0, 8'd254, 25'h0FFFFFF, 3'b100, rnd_ovf_res, rnd_ovf_flag, 1'b0, 3,
                     "round_ovf"});
    vecs.push_back('{1'b1, 8'd130, 25'h0A00000, 3'b000, 32'hC1200000, 1'b0, 1'b0, 3, "normal_neg"});
    vecs.push_back('{1'b0, 8'd100, 25'h0000000, 3'b100, 32'h26000000, 1'b0, 1'b0, 27, "max_shift"});

    reset       = 1'b1;
    in_valid    = 1'b0;
    in_sign     = 1'b0;
    in_exponent = '0;
    in_mant     = '0;
    in_grs      = '0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", res_bits, 32'd0);
    check("reset_flags", {30'd0, out_overflow, out_underflow}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1 check("idle_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i], 1'b1);

    // Backpressure: result held, new sums ignored while out_ready is low.
    run_vec(vecs[0], 1'b0);
    held = res_bits;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      in_valid    = (i % 2) == 0;
      in_exponent = 8'd10;
      in_mant     = 25'h0FFFFFF;
      @(posedge clock);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_result", res_bits, held);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);

    // Reset while shifting: sum abandoned, no output afterwards.
    @(negedge clock);
    in_sign     = 1'b0;
    in_exponent = 8'd100;
    in_mant     = '0;
    in_grs      = 3'b100;
    in_valid    = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    check("rst_mid_result", res_bits, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1 check("rst_mid_idle", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clock);
      #1 if (out_valid) seen = 1'b1;
    end
    check("rst_mid_no_output", 32'(seen), 32'd0);

    run_vec(vecs[1], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
